motor_pwm_gen: RTL and testbench
================================

// Module: motor_pwm_gen
// PURPOSE
//  Consumes the 8x-interpolated duty stream from the B-spline smoothing stage and drives one
//  H-bridge channel (pwm_a = forward leg, pwm_b = reverse leg). Samples duty/dir once per PWM
//  period, generates edge-aligned PWM, handles brake, and optionally inserts dead time on reversal.
// PARAMETERS
//  DUTY_W    8   width of duty input (smoothing-stage output width)
//  CNT_W     8   PWM counter width; period = 2**CNT_W clk cycles
//  DEAD_CYC  32  dead-time length in clk cycles (used only with MOTOR_PWM_DEADTIME_EN); must be >= 1
// PORTS
//  clk           in   1       system clock
//  rst           in   1       synchronous reset, active-high
//  enable        in   1       1 = bridge driven; 0 = both legs off
//  brake         in   1       1 = short-brake (both legs high)
//  duty          in   DUTY_W  unsigned duty from smoothing stage
//  dir           in   1       0 = forward (pwm_a), 1 = reverse (pwm_b)
//  pwm_a         out  1       forward-leg gate, registered
//  pwm_b         out  1       reverse-leg gate, registered
//  period_start  out  1       1-cycle pulse, coincides with the cycle cnt==0 in RUN
//  duty_q        out  DUTY_W  duty value governing the current period
// BEHAVIOUR
//  - One clock, reset synchronous active-high. Reset: state=OFF, cnt=0, pwm_a=pwm_b=0,
//    period_start=0, duty_q=0, dir_q=0. rst asserted mid-period: all of the above on next edge.
//  - States: OFF, RUN, DEAD, BRAKE. Priority each cycle: rst > ~enable > brake > normal.
//  - OFF: outputs low, cnt held 0. enable=1 -> RUN next cycle, cnt=0, duty_q/dir_q loaded from
//    inputs in that same transition; period_start pulses in the first RUN cycle.
//  - RUN: cnt increments every cycle, wraps 2**CNT_W-1 -> 0. Threshold thr = top CNT_W bits of
//    duty_q if DUTY_W>=CNT_W, else duty_q zero-padded on the LSB side to CNT_W bits.
//    active = (cnt < thr) | (duty_q == all-ones)  (all-ones = 100 %, 0 = 0 %).
//    pwm_a = active & ~dir_q; pwm_b = active & dir_q. Never both high in RUN.
//  - Sampling: duty and dir sampled only in the cycle cnt==2**CNT_W-1; new values govern outputs
//    from the next cnt==0. Mid-period changes are ignored until that boundary.
//  - Direction change (sampled dir != dir_q at boundary): see CONFIGURATION.
//  - ~enable in any state: OFF next cycle, outputs low next cycle, regardless of cnt.
//  - BRAKE: brake=1 in RUN/DEAD -> BRAKE next cycle, pwm_a=pwm_b=1, cnt held 0. brake=0 ->
//    leave BRAKE through DEAD (macro defined) or straight to RUN at cnt=0 (macro undefined),
//    reloading duty_q/dir_q from inputs. brake in OFF is ignored.
//  - Output latency: registered; a state transition decided in cycle n is visible in cycle n+1.
// CONFIGURATION
//  MOTOR_PWM_DEADTIME_EN defined: on a direction change at the boundary, or on brake release,
//    enter DEAD: both legs low for exactly DEAD_CYC cycles (dead counter, cnt held 0), then RUN
//    with cnt=0 and period_start pulse. ~enable/brake in DEAD obey the normal priority.
//  Undefined: no DEAD state; reversal switches legs directly at cnt==0 and brake release goes
//    straight to RUN. DEAD_CYC is unused.
// TESTING (DUTY_W=8, CNT_W=8, DEAD_CYC=4)
//  1 rst, then enable=1 dir=0 duty=64 -> pwm_a high 64 of every 256 cycles, pwm_b=0,
//    period_start every 256 cycles aligned to pwm_a rising edge.
//  2 duty=0 -> both legs low the full period; duty=255 -> pwm_a high all 256 cycles.
//  3 duty 64->128 at cnt=100 -> current period keeps 64 high cycles, next period 128; duty_q
//    updates at cnt==0.
//  4 dir 0->1 at cnt=50, macro defined -> pwm_a completes its period, 4 cycles both low,
//    then pwm_b high 64 cycles; macro undefined -> pwm_b rises exactly at next cnt==0.
//  5 brake=1 at cnt=30 -> both legs high next cycle; brake=0 -> (macro) 4 low cycles then RUN
//    at cnt=0; enable=0 while brake=1 -> both low next cycle (OFF wins).
//  6 rst=1 at cnt=20 while pwm_a=1 -> pwm_a, pwm_b, period_start, duty_q all 0 next cycle;
//    after release with enable=1, RUN resumes at cnt=0.

Source files
------------

// File: rtl/motor_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : motor_pwm_gen
// Description : H-bridge PWM generator for one motor channel. Samples the
//               interpolated duty/dir stream once per PWM period. Generates
//               edge-aligned PWM on the forward (pwm_a) or reverse (pwm_b)
//               leg and handles short-brake. Optional dead time is inserted
//               on reversal and on brake release.
// Options     : MOTOR_PWM_DEADTIME_EN - when defined, enables the DEAD state.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_pwm_gen #(
    parameter int DUTY_W   = 8,
    parameter int CNT_W    = 8,
    parameter int DEAD_CYC = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              brake,
    input  logic [DUTY_W-1:0] duty,
    input  logic              dir,
    output logic              pwm_a,
    output logic              pwm_b,
    output logic              period_start,
    output logic [DUTY_W-1:0] duty_q
);

    // Dead counter holds DEAD_CYC-1 down to 0, one value per dead cycle.
    localparam int              c_DEAD_W  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_RUN   = 2'd1,
        S_DEAD  = 2'd2,
        S_BRAKE = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DUTY_W-1:0]   r_duty_q;
    logic                r_dir_q;
    logic [c_DEAD_W-1:0] r_dead_cnt;
    logic                r_pwm_a;
    logic                r_pwm_b;
    logic                r_period_start;

    state_t              w_nxt_state;
    logic [CNT_W-1:0]    w_nxt_cnt;
    logic [DUTY_W-1:0]   w_nxt_duty;
    logic                w_nxt_dir;
    logic [c_DEAD_W-1:0] w_nxt_dead;
    logic [CNT_W-1:0]    w_thr;
    logic                w_active;
    logic                w_nxt_pwm_a;
    logic                w_nxt_pwm_b;
    logic                w_nxt_period_start;

    // Next-state decision: ~enable overrides everything, then brake, then
    // normal period sequencing. duty/dir are only loaded at period boundaries,
    // on leaving OFF and on brake release.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_duty  = r_duty_q;
        w_nxt_dir   = r_dir_q;
        w_nxt_dead  = r_dead_cnt;

        if (!enable) begin
            w_nxt_state = S_OFF;
            w_nxt_cnt   = '0;
            w_nxt_dead  = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    // brake is ignored here; the bridge starts running first
                    w_nxt_state = S_RUN;
                    w_nxt_cnt   = '0;
                    w_nxt_duty  = duty;
                    w_nxt_dir   = dir;
                end

                S_RUN: begin
                    if (brake) begin
                        w_nxt_state = S_BRAKE;
                        w_nxt_cnt   = '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        w_nxt_cnt  = '0;
                        w_nxt_duty = duty;
                        w_nxt_dir  = dir;
`ifdef MOTOR_PWM_DEADTIME_EN
                        // reversal: both legs off before the other leg fires
                        if (dir != r_dir_q) begin
                            w_nxt_state = S_DEAD;
                            w_nxt_dead  = c_DEAD_W'(DEAD_CYC - 1);
                        end
`endif
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end

                S_DEAD: begin
                    w_nxt_cnt = '0;
                    if (brake) begin
                        w_nxt_state = S_BRAKE;
                    end else if (r_dead_cnt == '0) begin
                        w_nxt_state = S_RUN;
                    end else begin
                        w_nxt_dead = r_dead_cnt - 1'b1;
                    end
                end

                S_BRAKE: begin
                    w_nxt_cnt = '0;
                    if (!brake) begin
                        w_nxt_duty = duty;
                        w_nxt_dir  = dir;
`ifdef MOTOR_PWM_DEADTIME_EN
                        w_nxt_state = S_DEAD;
                        w_nxt_dead  = c_DEAD_W'(DEAD_CYC - 1);
`else
                        w_nxt_state = S_RUN;
`endif
                    end
                end

                default: begin
                    w_nxt_state = S_OFF;
                    w_nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Compare threshold: MSB-aligned duty, whatever the relative widths.
    generate
        if (DUTY_W >= CNT_W) begin : g_thr_trunc
            assign w_thr = w_nxt_duty[DUTY_W-1 -: CNT_W];
        end else begin : g_thr_pad
            assign w_thr = {w_nxt_duty, {(CNT_W - DUTY_W){1'b0}}};
        end
    endgenerate

    // Output decode from the next state, so registered outputs line up with the
    // counter value of the cycle they are visible in.
    always_comb begin
        w_active           = (w_nxt_cnt < w_thr) || (w_nxt_duty == {DUTY_W{1'b1}});
        w_nxt_pwm_a        = 1'b0;
        w_nxt_pwm_b        = 1'b0;
        w_nxt_period_start = 1'b0;
        case (w_nxt_state)
            S_RUN: begin
                w_nxt_pwm_a        = w_active & ~w_nxt_dir;
                w_nxt_pwm_b        = w_active &  w_nxt_dir;
                w_nxt_period_start = (w_nxt_cnt == '0);
            end
            S_BRAKE: begin
                w_nxt_pwm_a = 1'b1;
                w_nxt_pwm_b = 1'b1;
            end
            default: begin
                w_nxt_pwm_a = 1'b0;
                w_nxt_pwm_b = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_OFF;
            r_cnt          <= '0;
            r_duty_q       <= '0;
            r_dir_q        <= 1'b0;
            r_dead_cnt     <= '0;
            r_pwm_a        <= 1'b0;
            r_pwm_b        <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_state        <= w_nxt_state;
            r_cnt          <= w_nxt_cnt;
            r_duty_q       <= w_nxt_duty;
            r_dir_q        <= w_nxt_dir;
            r_dead_cnt     <= w_nxt_dead;
            r_pwm_a        <= w_nxt_pwm_a;
            r_pwm_b        <= w_nxt_pwm_b;
            r_period_start <= w_nxt_period_start;
        end
    end

    assign pwm_a        = r_pwm_a;
    assign pwm_b        = r_pwm_b;
    assign period_start = r_period_start;
    assign duty_q       = r_duty_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_pwm_gen
// Description : Self-checking bench for motor_pwm_gen (DUTY_W=8, CNT_W=8,
//               DEAD_CYC=4). A cycle model pushes expected outputs into a
//               scoreboard queue as stimulus is driven. Per-period leg counts
//               are checked against fixed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_pwm_gen;

    localparam int c_DEAD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       brake = 1'b0;
    logic [7:0] duty = 8'd0;
    logic       dir = 1'b0;
    logic       pwm_a;
    logic       pwm_b;
    logic       period_start;
    logic [7:0] duty_q;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: 0 OFF, 1 RUN, 2 DEAD, 3 BRAKE
    int         m_state = 0;
    int         m_cnt   = 0;
    int         m_left  = 0;
    logic [7:0] m_duty  = 8'd0;
    logic       m_dir   = 1'b0;

    logic [10:0] sb_q[$];

    motor_pwm_gen #(
        .DUTY_W   (8),
        .CNT_W    (8),
        .DEAD_CYC (c_DEAD)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .brake        (brake),
        .duty         (duty),
        .dir          (dir),
        .pwm_a        (pwm_a),
        .pwm_b        (pwm_b),
        .period_start (period_start),
        .duty_q       (duty_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit dead_en;
`ifdef MOTOR_PWM_DEADTIME_EN
        dead_en = 1'b1;
`else
        dead_en = 1'b0;
`endif
        if (rst) begin
            m_state = 0; m_cnt = 0; m_duty = 8'd0; m_dir = 1'b0; m_left = 0;
        end else if (!enable) begin
            m_state = 0; m_cnt = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_cnt = 0; m_duty = duty; m_dir = dir;
        end else if (m_state == 3) begin
            if (!brake) begin
                m_duty = duty; m_dir = dir; m_cnt = 0;
                if (dead_en) begin m_state = 2; m_left = c_DEAD; end
                else m_state = 1;
            end
        end else if (brake) begin
            m_state = 3; m_cnt = 0;
        end else if (m_state == 2) begin
            if (m_left == 1) m_state = 1;
            else m_left--;
        end else if (m_cnt == 255) begin
            if (dead_en && dir != m_dir) begin m_state = 2; m_left = c_DEAD; end
            m_cnt = 0; m_duty = duty; m_dir = dir;
        end else begin
            m_cnt++;
        end
    endtask

    function automatic logic [10:0] model_out();
        logic on;
        logic a, b, ps;
        on = (m_cnt < int'(m_duty)) || (m_duty == 8'hFF);
        a  = (m_state == 3) || (m_state == 1 && on && !m_dir);
        b  = (m_state == 3) || (m_state == 1 && on &&  m_dir);
        ps = (m_state == 1) && (m_cnt == 0);
        return {a, b, ps, m_duty};
    endfunction

    // One clock: predict, push, clock, then pop and compare.
    task automatic tick();
        logic [10:0] exp_v;
        model_step();
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            exp_v = sb_q.pop_front();
            chk("cycle", {21'd0, pwm_a, pwm_b, period_start, duty_q}, {21'd0, exp_v});
        end
    endtask

    // Tick until the model reports RUN at the given count (bounded).
    task automatic tick_until(input int target);
        int k = 0;
        while (!(m_state == 1 && m_cnt == target) && k < 600) begin
            tick();
            k++;
        end
        if (k >= 600) chk("wait_timeout", 32'd0, 32'd1);
    endtask

    // Run one full period from the next cnt==0, optionally changing inputs mid-way.
    task automatic run_period(input int chg_at, input logic [7:0] nd, input logic ndir,
                              output int na, output int nb, output int ps);
        na = 0; nb = 0; ps = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == chg_at) begin duty = nd; dir = ndir; end
            tick();
            na += int'(pwm_a);
            nb += int'(pwm_b);
            ps += int'(period_start);
        end
    endtask

    initial begin
        int na, nb, ps, low;

        // 1: reset, then forward 25 %
        tick(); tick();
        chk("rst_state", {28'd0, pwm_a, pwm_b, period_start, 1'b0} | {24'd0, duty_q}, 32'd0);
        rst = 1'b0; enable = 1'b1; dir = 1'b0; duty = 8'd64;
        tick();
        chk("first_ps", {31'd0, period_start}, 32'd1);
        chk("first_a", {31'd0, pwm_a}, 32'd1);
        tick_until(255);
        run_period(-1, 8'd0, 1'b0, na, nb, ps);
        chk("d64_a", na, 64); chk("d64_b", nb, 0); chk("d64_ps", ps, 1);

        // 2: 0 % and 100 %
        duty = 8'd0;
        run_period(-1, 8'd0, 1'b0, na, nb, ps);
        chk("d0_a", na, 0); chk("d0_b", nb, 0);
        duty = 8'd255;
        run_period(-1, 8'd0, 1'b0, na, nb, ps);
        chk("d255_a", na, 256); chk("d255_b", nb, 0);

        // 3: mid-period duty change takes effect next period
        duty = 8'd64;
        run_period(100, 8'd64, 1'b0, na, nb, ps);
        run_period(100, 8'd128, 1'b0, na, nb, ps);
        chk("mid_keep", na, 64);
        chk("mid_dq", {24'd0, duty_q}, 32'd64);
        run_period(-1, 8'd0, 1'b0, na, nb, ps);
        chk("mid_new", na, 128);

        // 4: reversal at cnt 50
        duty = 8'd64;
        run_period(-1, 8'd0, 1'b0, na, nb, ps);
        run_period(50, 8'd64, 1'b1, na, nb, ps);
        chk("rev_old_a", na, 64); chk("rev_old_b", nb, 0);
`ifdef MOTOR_PWM_DEADTIME_EN
        low = 0;
        for (int i = 0; i < c_DEAD; i++) begin
            tick();
            low += int'(!pwm_a && !pwm_b);
        end
        chk("rev_dead", low, c_DEAD);
`endif
        run_period(-1, 8'd0, 1'b0, na, nb, ps);
        chk("rev_new_a", na, 0); chk("rev_new_b", nb, 64); chk("rev_ps", ps, 1);

        // 5: brake at cnt 30, release, then enable drop while braking
        tick_until(30);
        brake = 1'b1;
        tick();
        chk("brake_legs", {30'd0, pwm_a, pwm_b}, 32'd3);
        tick(); tick(); tick();
        brake = 1'b0;
`ifdef MOTOR_PWM_DEADTIME_EN
        low = 0;
        for (int i = 0; i < c_DEAD; i++) begin
            tick();
            low += int'(!pwm_a && !pwm_b);
        end
        chk("brk_dead", low, c_DEAD);
`endif
        tick();
        chk("brk_rel_ps", {31'd0, period_start}, 32'd1);
        brake = 1'b1;
        tick();
        chk("brake2_legs", {30'd0, pwm_a, pwm_b}, 32'd3);
        enable = 1'b0;
        tick();
        chk("off_wins", {30'd0, pwm_a, pwm_b}, 32'd0);
        brake = 1'b0;
        tick();

        // 6: reset mid-period while pwm_a is high
        dir = 1'b0; duty = 8'd64; enable = 1'b1;
        tick();
        tick_until(20);
        chk("pre_rst_a", {31'd0, pwm_a}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst", {21'd0, pwm_a, pwm_b, period_start, duty_q}, 32'd0);
        rst = 1'b0;
        tick();
        chk("resume_ps", {31'd0, period_start}, 32'd1);
        chk("resume_dq", {24'd0, duty_q}, 32'd64);
        run_period(-1, 8'd0, 1'b0, na, nb, ps);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
